multi_blink: RTL and testbench
==============================

MULTI_BLINK -- requirements
Module: multi_blink

Interface
REQ-001 SHALL have parameter FREQ, default 50_000_000, meaning the input clock frequency in Hz.
REQ-002 SHALL have parameter TICK_HZ, default 1000, meaning the base timing tick rate in Hz.
REQ-003 SHALL have parameter CHANNELS, default 4, meaning the number of independent LED outputs (1..16).
REQ-004 SHALL have parameter PERIOD_W, default 12, meaning the width in bits of the per-channel period and duty fields, counted in ticks.
REQ-005 SHALL have port clk_i, input, 1, the single system clock.
REQ-006 SHALL have port rst_ni, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have port cfg_valid_i, input, 1, the configuration write request.
REQ-008 SHALL have port cfg_ready_o, output, 1, meaning the block can accept a configuration write.
REQ-009 SHALL have port cfg_chan_i, input, max(1,$clog2(CHANNELS)), the target channel index.
REQ-010 SHALL have port cfg_mode_i, input, 2, the mode: 0 OFF, 1 ON, 2 BLINK, 3 PULSE.
REQ-011 SHALL have port cfg_period_i, input, PERIOD_W, the period in ticks.
REQ-012 SHALL have port cfg_duty_i, input, PERIOD_W, the high time in ticks.
REQ-013 SHALL have port led_o, output, CHANNELS, the registered LED drive, bit n for channel n.

Function
REQ-014 SHALL derive DIV = FREQ/TICK_HZ (integer), with a prescaler counting 0..DIV-1 and a one-cycle tick when it wraps from DIV-1 to 0; DIV<1 SHALL be a elaboration error.
REQ-015 SHALL assert cfg_ready_o whenever rst_ni is high; a write is accepted when cfg_valid_i and cfg_ready_o are both high on a rising clk_i edge.
REQ-016 SHALL ignore accepted writes with cfg_chan_i >= CHANNELS (no state change).
REQ-017 SHALL, on an accepted write, load mode/period/duty into the channel and clear its tick counter to 0; led_o reflects the new setting on the cycle after acceptance (1-cycle latency).
REQ-018 SHALL treat period 0 as period 1.
REQ-019 SHALL hold channel counter cnt in 0..period-1, incremented on each tick and wrapping from period-1 to 0.
REQ-020 SHALL drive led_o[n] as: OFF -> 0; ON -> 1; BLINK -> (cnt < duty); duty 0 -> constantly 0; duty >= period -> constantly 1.
REQ-021 SHALL, in PULSE mode, drive led high from acceptance until duty ticks have elapsed, then set the channel mode to OFF and drive 0; duty 0 SHALL go straight to OFF.
REQ-022 SHALL give a write priority over a tick arriving in the same cycle for the addressed channel: the counter becomes 0 and the tick is not counted for it; other channels count normally.
REQ-023 SHALL keep all channels free-running from the shared tick; channels are never phase-realigned except by a write.

Reset
REQ-024 SHALL, on rst_ni low, asynchronously clear the prescaler, all counters, all modes to OFF, all periods/duties to 0, led_o to all zeros, and cfg_ready_o to 0.
REQ-025 SHALL abandon any in-progress blink or pulse on reset mid-operation; after release, the first tick occurs DIV cycles later.

Configuration
REQ-026 SHALL honour macro MULTI_BLINK_PULSE_EN: when defined, mode 3 behaves per REQ-021; when undefined, the PULSE logic is not built and mode 3 behaves exactly as BLINK.

Structure
REQ-027 SHALL place the mode encoding (typedef for the 2-bit mode plus named constants OFF/ON/BLINK/PULSE) and the DIV computation in a shared package multi_blink_pkg.
REQ-028 SHALL implement the per-channel counter/mode/output logic as sub-module blink_chan, instantiated CHANNELS times; the prescaler and write decode stay in multi_blink.

Verification (FREQ=1000, TICK_HZ=100, DIV=10, CHANNELS=4, PERIOD_W=8)
REQ-029 SHALL cover: write ch0 BLINK period 4 duty 2 -> led_o[0] high for 20 cycles and then low for 20, repeating; other bits 0.
REQ-030 SHALL cover: write ch1 ON, then ch1 OFF 5 cycles later -> led_o[1] is 1 from the cycle after the first write and 0 from the cycle after the second.
REQ-031 SHALL cover: with macro defined, write ch2 PULSE duty 3 -> led_o[2] is high for about 3 ticks (30 cycles ±10) and then stays 0; without the macro -> it repeats as BLINK.
REQ-032 SHALL cover: BLINK with duty 0 -> constant 0; duty 9 period 4 -> constant 1; period 0 duty 1 -> constant 1.
REQ-033 SHALL cover: a write to ch3 on the tick cycle -> ch3 counter reads 0 afterwards, while ch0 advances; a write with cfg_chan_i=5 (3-bit index build) -> no change.
REQ-034 SHALL cover: rst_ni dropped mid-blink without a clock edge -> led_o=0 and cfg_ready_o=0 immediately; after release, all channels are OFF.

Source files
------------

// File: rtl/multi_blink_pkg.sv
// Shared definitions for multi_blink: channel mode encoding and tick divider computation.
package multi_blink_pkg;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    ON    = 2'd1,
    BLINK = 2'd2,
    PULSE = 2'd3
  } mode_e;

  // Clock cycles per base tick; a non-positive tick rate yields 0 so the top rejects it.
  function automatic int calc_div(input int freq, input int tick_hz);
    return (tick_hz > 0) ? freq / tick_hz : 0;
  endfunction

endpackage

// File: rtl/blink_chan.sv
// One LED channel: mode/period/duty registers, tick counter and registered LED drive.
// Optional one-shot PULSE mode is built when MULTI_BLINK_PULSE_EN is defined.
module blink_chan
  import multi_blink_pkg::*;
#(
  parameter int PERIOD_W = 12
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                tick_i,
  input  logic                wr_i,
  input  logic [1:0]          mode_i,
  input  logic [PERIOD_W-1:0] period_i,
  input  logic [PERIOD_W-1:0] duty_i,
  output logic                led_o
);

  mode_e               mode_q, mode_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic [PERIOD_W-1:0] duty_q, duty_d;
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  logic [PERIOD_W-1:0] last_q;
  logic                led_q, led_d;

  // Period 0 behaves like period 1, so the counter then stays at 0.
  assign last_q = (period_q == '0) ? '0 : period_q - 1'b1;

  always_comb begin
    mode_d   = mode_q;
    period_d = period_q;
    duty_d   = duty_q;
    cnt_d    = cnt_q;
    if (wr_i) begin
      mode_d   = mode_e'(mode_i);
      period_d = period_i;
      duty_d   = duty_i;
      cnt_d    = '0;
`ifdef MULTI_BLINK_PULSE_EN
      if (mode_e'(mode_i) == PULSE && duty_i == '0) begin
        mode_d = OFF;
      end
`endif
    end else if (tick_i) begin
      cnt_d = (cnt_q >= last_q) ? '0 : cnt_q + 1'b1;
`ifdef MULTI_BLINK_PULSE_EN
      // A pulse counts ticks since acceptance regardless of period, then retires to OFF.
      if (mode_q == PULSE) begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_d >= duty_q) begin
          mode_d = OFF;
          cnt_d  = '0;
        end
      end
`endif
    end

    led_d = 1'b0;
    case (mode_d)
      OFF:     led_d = 1'b0;
      ON:      led_d = 1'b1;
`ifdef MULTI_BLINK_PULSE_EN
      PULSE:   led_d = 1'b1;
`endif
      default: led_d = (cnt_d < duty_d);
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q   <= OFF;
      period_q <= '0;
      duty_q   <= '0;
      cnt_q    <= '0;
      led_q    <= 1'b0;
    end else begin
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      cnt_q    <= cnt_d;
      led_q    <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: rtl/multi_blink.sv
// Multi-channel LED blinker: shared tick prescaler, config write decode, CHANNELS blink_chan.
// Build with MULTI_BLINK_PULSE_EN defined to enable the one-shot PULSE mode.
module multi_blink
  import multi_blink_pkg::*;
#(
  parameter int FREQ     = 50_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int CHANNELS = 4,
  parameter int PERIOD_W = 12,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [CW-1:0]       cfg_chan_i,
  input  logic [1:0]          cfg_mode_i,
  input  logic [PERIOD_W-1:0] cfg_period_i,
  input  logic [PERIOD_W-1:0] cfg_duty_i,
  output logic [CHANNELS-1:0] led_o
);

  localparam int DIV = calc_div(FREQ, TICK_HZ);
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;

  if (DIV < 1) begin : g_bad_div
    $error("multi_blink: FREQ/TICK_HZ must be at least 1");
  end
  if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_channels
    $error("multi_blink: CHANNELS must be in 1..16");
  end

  logic [PW-1:0] pre_q, pre_d;
  logic          tick;
  logic          wr_accept;
  logic          chan_ok;

  always_comb begin
    tick  = (pre_q == PW'(DIV - 1));
    pre_d = tick ? '0 : pre_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end

  // Ready follows reset directly so it drops the instant reset is asserted.
  assign cfg_ready_o = rst_ni;
  assign wr_accept   = cfg_valid_i & cfg_ready_o;
  assign chan_ok     = (int'(cfg_chan_i) < CHANNELS);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic wr_sel;
    assign wr_sel = wr_accept & chan_ok & (int'(cfg_chan_i) == gi);

    blink_chan #(
      .PERIOD_W (PERIOD_W)
    ) u_chan (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .tick_i   (tick),
      .wr_i     (wr_sel),
      .mode_i   (cfg_mode_i),
      .period_i (cfg_period_i),
      .duty_i   (cfg_duty_i),
      .led_o    (led_o[gi])
    );
  end

endmodule

// File: tb/tb_multi_blink.sv
// Directed bench for multi_blink at FREQ=1000, TICK_HZ=100 (10 cycles per tick).
// A second instance with CHANNELS=5 exercises an out-of-range channel index.
module tb_multi_blink;
  import multi_blink_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_chan;
  logic [1:0] cfg_mode;
  logic [7:0] cfg_period;
  logic [7:0] cfg_duty;
  logic [3:0] led;

  logic       v5;
  logic       rdy5;
  logic [2:0] ch5;
  logic [1:0] mode5;
  logic [7:0] per5;
  logic [7:0] duty5;
  logic [4:0] led5;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  multi_blink #(
    .FREQ     (1000),
    .TICK_HZ  (100),
    .CHANNELS (4),
    .PERIOD_W (8)
  ) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_chan_i   (cfg_chan),
    .cfg_mode_i   (cfg_mode),
    .cfg_period_i (cfg_period),
    .cfg_duty_i   (cfg_duty),
    .led_o        (led)
  );

  multi_blink #(
    .FREQ     (1000),
    .TICK_HZ  (100),
    .CHANNELS (5),
    .PERIOD_W (8)
  ) u_dut5 (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cfg_valid_i  (v5),
    .cfg_ready_o  (rdy5),
    .cfg_chan_i   (ch5),
    .cfg_mode_i   (mode5),
    .cfg_period_i (per5),
    .cfg_duty_i   (duty5),
    .led_o        (led5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance until the most recent edge index modulo 10 equals p.
  task automatic goto_phase(input int p);
    do step(); while (cyc % 10 != p);
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] mode,
                    input logic [7:0] per, input logic [7:0] duty);
    cfg_valid  = 1'b1;
    cfg_chan   = ch;
    cfg_mode   = mode;
    cfg_period = per;
    cfg_duty   = duty;
    step();
    cfg_valid  = 1'b0;
  endtask

  task automatic wr5(input logic [2:0] ch, input logic [1:0] mode);
    v5    = 1'b1;
    ch5   = ch;
    mode5 = mode;
    per5  = 8'd4;
    duty5 = 8'd2;
    step();
    v5    = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_valid = 1'b0; cfg_chan = '0; cfg_mode = '0; cfg_period = '0; cfg_duty = '0;
    v5 = 1'b0; ch5 = '0; mode5 = '0; per5 = '0; duty5 = '0;

    // Reset state
    step();
    step();
    chk("rst_led", led, 4'b0000);
    chk("rst_ready", cfg_ready, 1'b0);
    rst_n = 1'b1;
    cyc = 0;
    chk("rel_ready", cfg_ready, 1'b1);
    chk("rel_led", led, 4'b0000);

    // ch0 BLINK period 4 duty 2, written on a tick edge: 20 high / 20 low
    goto_phase(9);
    wr(2'd0, BLINK, 8'd4, 8'd2);
    for (int i = 0; i < 80; i++) begin
      chk($sformatf("blink_%0d", i), led, {3'b000, ((i / 20) % 2 == 0)});
      step();
    end
    wr(2'd0, OFF, 8'd0, 8'd0);
    chk("blink_off", led, 4'b0000);

    // ch1 ON, then OFF five cycles later
    wr(2'd1, ON, 8'd0, 8'd0);
    chk("on_0", led[1], 1'b1);
    for (int i = 1; i < 5; i++) begin
      step();
      chk($sformatf("on_%0d", i), led[1], 1'b1);
    end
    wr(2'd1, OFF, 8'd0, 8'd0);
    chk("off_0", led[1], 1'b0);
    step();
    chk("off_1", led[1], 1'b0);

    // ch2 PULSE duty 3 period 8, written on a tick edge
    goto_phase(9);
    wr(2'd2, PULSE, 8'd8, 8'd3);
    for (int i = 0; i < 90; i++) begin
`ifdef MULTI_BLINK_PULSE_EN
      chk($sformatf("pulse_%0d", i), led[2], (i < 30));
`else
      chk($sformatf("pulse_%0d", i), led[2], (i < 30) || (i >= 80));
`endif
      step();
    end
    wr(2'd2, PULSE, 8'd8, 8'd0);
    chk("pulse_d0_a", led[2], 1'b0);
    step();
    chk("pulse_d0_b", led[2], 1'b0);
    wr(2'd2, OFF, 8'd0, 8'd0);

    // Duty/period boundaries on ch0
    wr(2'd0, BLINK, 8'd4, 8'd0);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("duty0_%0d", i), led[0], 1'b0);
      step();
    end
    wr(2'd0, BLINK, 8'd4, 8'd9);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("duty9_%0d", i), led[0], 1'b1);
      step();
    end
    wr(2'd0, BLINK, 8'd0, 8'd1);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("per0_%0d", i), led[0], 1'b1);
      step();
    end

    // Write to ch3 on a tick edge: ch3 restarts at 0 while ch0 keeps counting
    goto_phase(9);
    wr(2'd0, BLINK, 8'd4, 8'd2);
    goto_phase(9);
    wr(2'd3, BLINK, 8'd2, 8'd1);
    for (int i = 0; i < 40; i++) begin
      chk($sformatf("wrtick_%0d", i), led,
          {((i / 10) % 2 == 0), 2'b00, ((i < 10) || (i >= 30))});
      step();
    end

    // Out-of-range channel on the 5-channel instance is ignored
    wr5(3'd0, ON);
    chk("ch5_base", led5, 5'b00001);
    wr5(3'd5, ON);
    chk("ch5_bad_a", led5, 5'b00001);
    step();
    chk("ch5_bad_b", led5, 5'b00001);
    wr5(3'd4, ON);
    chk("ch5_good", led5, 5'b10001);

    // Asynchronous reset mid-blink, away from any clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_led", led, 4'b0000);
    chk("arst_ready", cfg_ready, 1'b0);
    chk("arst_led5", led5, 5'b00000);
    chk("arst_ready5", rdy5, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    cyc = 0;
    chk("rel2_ready", cfg_ready, 1'b1);
    chk("rel2_led", led, 4'b0000);
    // First tick must land on edge 10 after release
    wr(2'd0, BLINK, 8'd2, 8'd1);
    for (int i = 1; i < 30; i++) begin
      chk($sformatf("postrst_%0d", i), led, {3'b000, ((i / 10) % 2 == 0)});
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
